// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and RAM-side signals of the
// single-port memory arbiter, grouped for port passing.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        fault;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ramload, ramstate,
    output iwait, iload, dwait, dload,
    output ramREN, ramWEN, ramaddr, ramstore, fault
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    output ramload, ramstate,
    input  iwait, iload, dwait, dload,
    input  ramREN, ramWEN, ramaddr, ramstore, fault
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes instruction fetch and data access
// onto one RAM port, data first, with starvation guard and watchdog.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE, IGNT, DGNT, HALT
  } state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic [3:0] r_starve;
  logic [7:0] r_tmo;
  logic       r_fault;

  logic w_dreq;
  logic w_acc;
  logic w_err;
  logic w_ig;
  logic w_dg;
  logic w_iact;
  logic w_dact;
  logic w_starved;
  logic w_hang;

  assign w_dreq    = bus.dREN | bus.dWEN;
  assign w_acc     = bus.ramstate == RS_ACCESS;
  assign w_err     = bus.ramstate == RS_ERROR;
  assign w_ig      = r_state == IGNT;
  assign w_dg      = r_state == DGNT;
  assign w_iact    = w_ig & bus.iREN;
  assign w_dact    = w_dg & w_dreq;
  assign w_starved = bus.iREN & (r_starve == SMAX);
  assign w_hang    = w_err | (r_tmo == TLIM);

  // Grant FSM with starvation counter, watchdog and sticky fault
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_tmo    <= '0;
      r_fault  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_dreq && !w_starved) begin
            r_state <= DGNT;
            r_tmo   <= '0;
          end else if (bus.iREN) begin
            r_state <= IGNT;
            r_tmo   <= '0;
          end
        end
        IGNT: begin
          if (!bus.iREN) begin
            r_state <= IDLE;
          end else if (w_acc) begin
            r_state  <= IDLE;
            r_starve <= '0;
          end else if (w_hang) begin
            r_state <= HALT;
            r_fault <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        DGNT: begin
          if (!w_dreq) begin
            r_state <= IDLE;
          end else if (w_acc) begin
            r_state <= IDLE;
            if (!bus.iREN)
              r_starve <= '0;
            else if (r_starve != SMAX)
              r_starve <= r_starve + 4'd1;
          end else if (w_hang) begin
            r_state <= HALT;
            r_fault <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        HALT: r_state <= HALT;
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM strobes, mux and wait/load returns from state and request
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.iwait    = bus.iREN & ~(w_ig & w_acc);
    bus.dwait    = w_dreq & ~(w_dg & w_acc);
    bus.fault    = r_fault;
    if (w_iact) begin
      bus.ramREN  = 1'b1;
      bus.ramaddr = bus.iaddr;
      if (w_acc)
        bus.iload = bus.ramload;
    end
    if (w_dact) begin
      bus.ramaddr = bus.daddr;
      if (bus.dWEN) begin
        bus.ramWEN   = 1'b1;
        bus.ramstore = bus.dstore;
      end else begin
        bus.ramREN = 1'b1;
        if (w_acc)
          bus.dload = bus.ramload;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a completion scoreboard
// against a latency-programmable RAM model.
module tb_mem_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_MAX (4),
    .TIMEOUT    (8)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  localparam logic [1:0] K_I = 2'd0;
  localparam logic [1:0] K_R = 2'd1;
  localparam logic [1:0] K_W = 2'd2;
  localparam logic [1:0] K_X = 2'd3;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   ram_lat  = 1;
  int   ram_mode = 0;
  int   gcyc = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return a * 3 + 1;
  endfunction

  // RAM model: counts cycles of an ongoing strobe
  always @(posedge CLK)
    gcyc <= (bus.ramREN | bus.ramWEN) ? gcyc + 1 : 0;

  always_comb begin
    bus.ramstate = 2'd0;
    bus.ramload  = 32'd0;
    if (bus.ramREN | bus.ramWEN) begin
      case (ram_mode)
        0: bus.ramstate = (gcyc == ram_lat - 1) ? 2'd2 : 2'd1;
        1: bus.ramstate = 2'd1;
        default: bus.ramstate = 2'd3;
      endcase
    end
    if (bus.ramREN)
      bus.ramload = rd(bus.ramaddr);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic sb_pop(input string nm, input exp_t act);
    exp_t e;
    n_tot++;
    if (sbq.size() == 0) begin
      $display("FAIL %s: unexpected completion got %h", nm, act);
    end else begin
      e = sbq.pop_front();
      if (act === e) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  // Monitor: every completion is matched against the queue head
  always @(negedge CLK) begin
    exp_t a;
    if (!RST) begin
      if (bus.iREN && !bus.iwait) begin
        a = {K_I, bus.ramaddr, bus.iload};
        sb_pop("icomp", a);
      end
      if ((bus.dREN | bus.dWEN) && !bus.dwait) begin
        if (bus.ramWEN && !bus.ramREN)
          a = {K_W, bus.ramaddr, bus.ramstore};
        else if (bus.ramWEN)
          a = {K_X, bus.ramaddr, bus.ramstore};
        else
          a = {K_R, bus.ramaddr, bus.dload};
        sb_pop("dcomp", a);
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [1:0] k,
                      input logic [31:0] a,
                      input logic [31:0] d);
    exp_t e;
    e = {k, a, d};
    sbq.push_back(e);
  endtask

  task automatic wait_i(input int budget);
    bit done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge CLK);
      if (!bus.iwait) done = 1;
    end
    chk("iwait_bound", 32'(done), 32'd1);
  endtask

  task automatic wait_d(input int budget);
    bit done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge CLK);
      if (!bus.dwait) done = 1;
    end
    chk("dwait_bound", 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    bus.iREN   = 0;
    bus.iaddr  = 0;
    bus.dREN   = 0;
    bus.dWEN   = 0;
    bus.daddr  = 0;
    bus.dstore = 0;

    // reset state
    tick;
    tick;
    @(negedge CLK);
    chk("rst_ramREN", 32'(bus.ramREN), 0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_fault", 32'(bus.fault), 0);
    chk("rst_iload", bus.iload, 0);
    chk("rst_dload", bus.dload, 0);
    chk("rst_iwait", 32'(bus.iwait), 0);
    tick;
    bus.iREN = 1;
    bus.dREN = 1;
    @(negedge CLK);
    chk("rst_iwait_req", 32'(bus.iwait), 1);
    chk("rst_dwait_req", 32'(bus.dwait), 1);
    chk("rst_no_strobe", 32'(bus.ramREN), 0);
    tick;
    bus.iREN = 0;
    bus.dREN = 0;
    RST = 0;

    // instruction read, latency 2
    tick;
    ram_lat = 2;
    bus.iaddr = 32'h40;
    bus.iREN = 1;
    push(K_I, 32'h40, 32'h8C22_0004);
    @(negedge CLK);
    chk("i_lat_idle", 32'(bus.ramREN), 0);
    @(negedge CLK);
    chk("i_grant1", 32'(bus.ramREN), 1);
    chk("i_wait1", 32'(bus.iwait), 1);
    wait_i(10);
    tick;
    @(negedge CLK);
    chk("i_after", 32'(bus.ramREN), 0);
    chk("i_after_wait", 32'(bus.iwait), 1);
    bus.iREN = 0;

    // data read, latency 3
    tick;
    ram_lat = 3;
    bus.daddr = 32'h10;
    bus.dREN = 1;
    push(K_R, 32'h10, 32'h31);
    wait_d(10);
    tick;
    bus.dREN = 0;

    // starvation guard, latency 1
    tick;
    ram_lat = 1;
    bus.iaddr = 32'h60;
    bus.daddr = 32'h200;
    for (int k = 0; k < 4; k++)
      push(K_R, 32'h200, 32'h601);
    push(K_I, 32'h60, 32'h121);
    bus.iREN = 1;
    bus.dREN = 1;
    wait_i(40);
    tick;
    bus.iREN = 0;
    bus.dREN = 0;

    // priority: write wins, then the fetch
    tick;
    bus.iaddr  = 32'h44;
    bus.daddr  = 32'h100;
    bus.dstore = 32'hDEAD_BEEF;
    push(K_W, 32'h100, 32'hDEAD_BEEF);
    push(K_I, 32'h44, 32'hCD);
    bus.iREN = 1;
    bus.dWEN = 1;
    wait_d(10);
    tick;
    bus.dWEN = 0;
    wait_i(10);
    tick;
    bus.iREN = 0;

    // abort in the second IGNT cycle
    tick;
    ram_lat = 5;
    bus.iaddr = 32'h80;
    bus.iREN = 1;
    @(negedge CLK);
    @(negedge CLK);
    chk("ab_grant", 32'(bus.ramREN), 1);
    chk("ab_addr", bus.ramaddr, 32'h80);
    tick;
    bus.iREN = 0;
    @(negedge CLK);
    chk("ab_drop", 32'(bus.ramREN), 0);
    chk("ab_addr0", bus.ramaddr, 0);
    chk("ab_iload", bus.iload, 0);
    tick;
    ram_lat = 1;
    bus.iaddr = 32'h84;
    bus.iREN = 1;
    push(K_I, 32'h84, 32'h18D);
    wait_i(10);
    tick;
    bus.iREN = 0;

    // reset during a data grant
    tick;
    ram_lat = 5;
    bus.daddr = 32'h20;
    bus.dREN = 1;
    @(negedge CLK);
    @(negedge CLK);
    chk("rm_grant", 32'(bus.ramREN), 1);
    chk("rm_addr", bus.ramaddr, 32'h20);
    tick;
    RST = 1;
    tick;
    @(negedge CLK);
    chk("rm_ramREN", 32'(bus.ramREN), 0);
    chk("rm_ramaddr", bus.ramaddr, 0);
    chk("rm_dload", bus.dload, 0);
    chk("rm_dwait", 32'(bus.dwait), 1);
    chk("rm_fault", 32'(bus.fault), 0);
    tick;
    RST = 0;
    bus.dREN = 0;

    // ERROR during DGNT
    tick;
    ram_mode = 2;
    bus.daddr = 32'h30;
    bus.dREN = 1;
    @(negedge CLK);
    @(negedge CLK);
    chk("er_dwait1", 32'(bus.dwait), 1);
    @(negedge CLK);
    chk("er_fault", 32'(bus.fault), 1);
    chk("er_dwait", 32'(bus.dwait), 1);
    chk("er_strobe", 32'(bus.ramREN), 0);
    tick;
    bus.dREN = 0;
    RST = 1;
    ram_mode = 0;
    tick;
    RST = 0;
    @(negedge CLK);
    chk("er_clear", 32'(bus.fault), 0);

    // watchdog timeout with RAM stuck BUSY
    tick;
    ram_mode = 1;
    bus.iaddr = 32'h50;
    bus.iREN = 1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (bus.fault) break;
      if (bus.ramREN) cnt++;
    end
    chk("to_cycles", 32'(cnt), 8);
    chk("to_fault", 32'(bus.fault), 1);
    chk("to_strobe", 32'(bus.ramREN), 0);
    chk("to_iwait", 32'(bus.iwait), 1);
    tick;
    tick;
    tick;
    @(negedge CLK);
    chk("to_sticky", 32'(bus.fault), 1);
    bus.iREN = 0;
    RST = 1;
    tick;
    RST = 0;
    ram_mode = 0;
    @(negedge CLK);
    chk("to_clear", 32'(bus.fault), 0);

    tick;
    chk("sb_empty", 32'(sbq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
